countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Preset-and-expire down-counter; the counting-down counterpart of the free-running one-hot seconds timer.
- Loads a decimal preset (0-9 s), counts down at a 1 Hz tick derived from the system clock by cascaded prescalers, and flags expiry.
- Drives the board's 10-LED one-hot display and gives the control logic a done/expire indication.

Parameters:
DIV1, 50000, first prescaler ratio (clk cycles per stage-1 carry)
DIV2, 100, second prescaler ratio (stage-1 carries per 1 s tick)

Ports:
clk  input  1  system clock, all state updates on its rising edge
rst  input  1  asynchronous, active-low reset
load  input  1  strobe: capture preset
preset  input  4  decimal preset value; values above 9 clamp to 9
start  input  1  strobe: start or resume countdown
pause  input  1  strobe: suspend countdown
cnt  output  4  current remaining seconds, 0-9
sec  output  10  one-hot decode of cnt (bit n set when cnt==n)
running  output  1  high in RUN state
done  output  1  high in DONE state
expire  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, cnt=0, preset register=0, sec=10'b0000000001.
  - running=0, done=0, expire=0; both prescaler counters cleared.
- Prescalers:
  - Stage 1 counts 0..DIV1-1 and carries at DIV1-1.
  - Stage 2 advances only on a stage-1 carry; tick = (stage-2 at DIV2-1) AND stage-1 carry.
  - Both counters advance only in RUN, hold in PAUSE, and clear in IDLE/DONE and on every RUN entry from IDLE/DONE.
  - First tick therefore occurs exactly DIV1*DIV2 cycles after the edge that enters RUN.
- States:
  - IDLE: load -> preset_reg<=clamp(preset), cnt<=clamp(preset), stay IDLE. start (load low) -> RUN if cnt!=0, else DONE.
  - RUN: tick -> cnt<=cnt-1; tick with cnt==1 -> cnt<=0 and go to DONE. pause -> PAUSE. load ignored.
  - PAUSE: start -> RUN (prescalers resume, not cleared). load -> capture as in IDLE, go to IDLE. pause ignored.
  - DONE: load -> capture as in IDLE, go to IDLE. start -> cnt<=preset_reg, then RUN if preset_reg!=0, else re-enter DONE (expire pulses again).
- Outputs:
  - expire is registered and high for exactly the first cycle in DONE.
  - running and done are decoded from state.
  - sec is combinational from cnt; cnt never exceeds 9, so sec is always one-hot.
- Simultaneous events:
  - load and start in the same cycle: load wins, start ignored.
  - tick and pause in the same cycle in RUN: decrement applies and state goes to PAUSE. If that decrement reaches 0, DONE wins over PAUSE.
  - start and pause in the same cycle: RUN takes pause; PAUSE takes start.
- Reset mid-count: immediate return to reset values; preset_reg lost.
- Width rule: cnt decrements in 4 bits, never below 0 (a decrement from 0 cannot occur by construction).

Decomposition:
- Shared package: state encoding (IDLE, RUN, PAUSE, DONE as 2-bit constants), default DIV1/DIV2 constants, CNT_MAX=9.
- One sub-module: tick_gen (cascaded DIV1/DIV2 prescaler with enable and synchronous clear, output tick). The FSM, counter and decoder stay in countdown_timer.

Test Plan:
Use DIV1=4, DIV2=3 (tick every 12 cycles).
- Reset and load: hold rst low, release, load preset=3 -> cnt=3, sec=10'b0000001000, running=0, done=0.
- Full countdown: load 3, start -> running=1; cnt goes 2,1,0 at 12, 24, 36 cycles after start; DONE entered on the 36th cycle; expire high for 1 cycle; done stays 1, sec=10'b0000000001.
- Pause/resume: preset=5, start, pause 5 cycles into the countdown, hold 20 cycles, start -> cnt unchanged during pause; first decrement 7 cycles after resume.
- Boundaries:
  - preset=4'd12 -> cnt=9.
  - preset=0 then start -> DONE next cycle, expire pulse, cnt=0.
  - start in DONE after preset 2 -> reloads 2 and counts to 0 again.
- Simultaneous strobes: load+start together in IDLE -> stays IDLE with new preset. Pause coincident with the tick that takes cnt 1->0 -> DONE, expire=1.
- Async reset mid-run: preset=7, start, assert rst between clock edges at cnt=4 -> outputs return to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : countdown_timer_pkg                                       |
// | Brief    : Shared state encoding, limits and helpers for the timer   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package countdown_timer_pkg;

    localparam int STATE_W      = 2;
    localparam int CNT_W        = 4;
    localparam int SEC_W        = 10;
    localparam int DIV1_DEFAULT = 50000;
    localparam int DIV2_DEFAULT = 100;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd9;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] clamp_preset(input logic [CNT_W-1:0] value);
        return (value > CNT_MAX) ? CNT_MAX : value;
    endfunction

    // Only ever called with cnt <= CNT_MAX, so the result stays one-hot.
    function automatic logic [SEC_W-1:0] onehot_sec(input logic [CNT_W-1:0] value);
        return SEC_W'(1) << value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : countdown_timer_if                                        |
// | Brief    : Control strobes and status outputs of the countdown timer |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface countdown_timer_if;

    logic       load;
    logic [3:0] preset;
    logic       start;
    logic       pause;
    logic [3:0] cnt;
    logic [9:0] sec;
    logic       running;
    logic       done;
    logic       expire;

    modport master (
        output load, preset, start, pause,
        input  cnt, sec, running, done, expire
    );

    modport slave (
        input  load, preset, start, pause,
        output cnt, sec, running, done, expire
    );

endinterface
`default_nettype wire

// File: rtl/countdown_timer_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : countdown_timer_tick_gen                                  |
// | Brief    : Cascaded DIV1/DIV2 prescaler producing a one-cycle tick   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module countdown_timer_tick_gen #(
    parameter int DIV1 = 4,
    parameter int DIV2 = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);

    localparam int S1_W = (DIV1 > 1) ? $clog2(DIV1) : 1;
    localparam int S2_W = (DIV2 > 1) ? $clog2(DIV2) : 1;
    localparam logic [S1_W-1:0] C_S1_LAST = S1_W'(DIV1 - 1);
    localparam logic [S2_W-1:0] C_S2_LAST = S2_W'(DIV2 - 1);

    logic [S1_W-1:0] r_s1;
    logic [S2_W-1:0] r_s2;
    logic            w_carry1;

    assign w_carry1 = en && (r_s1 == C_S1_LAST);
    assign tick     = w_carry1 && (r_s2 == C_S2_LAST);

    // Clear dominates enable so a RUN entry always starts from a full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (clr) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else if (en) begin
            if (w_carry1) begin
                r_s1 <= '0;
                r_s2 <= (r_s2 == C_S2_LAST) ? '0 : r_s2 + 1'b1;
            end else begin
                r_s1 <= r_s1 + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : countdown_timer                                           |
// | Brief    : 0-9 s preset down-counter with pause, expiry and one-hot  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int DIV1 = DIV1_DEFAULT,
    parameter int DIV2 = DIV2_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    countdown_timer_if.slave   bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_preset;
    logic             r_expire;

    logic             w_tick;
    logic             w_en;
    logic             w_clr;
    logic [CNT_W-1:0] w_clamped;

    assign w_en      = (r_state == ST_RUN);
    assign w_clr     = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_clamped = clamp_preset(bus.preset);

    countdown_timer_tick_gen #(
        .DIV1 (DIV1),
        .DIV2 (DIV2)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_preset <= '0;
            r_expire <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.load) begin
                        r_preset <= w_clamped;
                        r_cnt    <= w_clamped;
                    end else if (bus.start) begin
                        if (r_cnt != '0) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state  <= ST_DONE;
                            r_expire <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Reaching zero takes priority over a coincident pause.
                    if (w_tick) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state  <= ST_DONE;
                            r_expire <= 1'b1;
                        end else if (bus.pause) begin
                            r_state <= ST_PAUSE;
                        end
                    end else if (bus.pause) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.load) begin
                        r_preset <= w_clamped;
                        r_cnt    <= w_clamped;
                        r_state  <= ST_IDLE;
                    end else if (bus.start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (bus.load) begin
                        r_preset <= w_clamped;
                        r_cnt    <= w_clamped;
                        r_state  <= ST_IDLE;
                    end else if (bus.start) begin
                        r_cnt <= r_preset;
                        if (r_preset != '0) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_expire <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cnt     = r_cnt;
    assign bus.sec     = onehot_sec(r_cnt);
    assign bus.running = (r_state == ST_RUN);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.expire  = r_expire;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_countdown_timer                                        |
// | Brief    : Directed and random bench with behavioural timer model    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_countdown_timer;

    localparam int DIV1   = 4;
    localparam int DIV2   = 3;
    localparam int PERIOD = DIV1 * DIV2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    countdown_timer_if bus ();

    countdown_timer #(
        .DIV1 (DIV1),
        .DIV2 (DIV2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: one modulo-PERIOD phase counter stands in for the prescaler pair.
    int m_state  = M_IDLE;
    int m_cnt    = 0;
    int m_preset = 0;
    int m_phase  = 0;
    int m_expire = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state  <= M_IDLE;
            m_cnt    <= 0;
            m_preset <= 0;
            m_phase  <= 0;
            m_expire <= 0;
        end else begin
            int  st, c, pr, ph, ex, cl;
            bit  tk;
            st = m_state; c = m_cnt; pr = m_preset; ex = 0;
            cl = (int'(bus.preset) > 9) ? 9 : int'(bus.preset);
            tk = (m_state == M_RUN) && (m_phase == PERIOD - 1);
            if (m_state == M_RUN)        ph = (m_phase + 1) % PERIOD;
            else if (m_state == M_PAUSE) ph = m_phase;
            else                         ph = 0;
            case (m_state)
                M_IDLE: begin
                    if (bus.load) begin pr = cl; c = cl; end
                    else if (bus.start) begin
                        if (c != 0) st = M_RUN;
                        else begin st = M_DONE; ex = 1; end
                    end
                end
                M_RUN: begin
                    if (tk) c = c - 1;
                    if (tk && c == 0) begin st = M_DONE; ex = 1; end
                    else if (bus.pause) st = M_PAUSE;
                end
                M_PAUSE: begin
                    if (bus.load) begin pr = cl; c = cl; st = M_IDLE; end
                    else if (bus.start) st = M_RUN;
                end
                default: begin
                    if (bus.load) begin pr = cl; c = cl; st = M_IDLE; end
                    else if (bus.start) begin
                        c = pr;
                        if (pr != 0) st = M_RUN;
                        else ex = 1;
                    end
                end
            endcase
            m_state  <= st;
            m_cnt    <= c;
            m_preset <= pr;
            m_phase  <= ph;
            m_expire <= ex;
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        int e_sec;
        e_sec = 1 << m_cnt;
        chk("model_cnt",     int'(bus.cnt),     m_cnt);
        chk("model_sec",     int'(bus.sec),     e_sec);
        chk("model_running", int'(bus.running), int'(m_state == M_RUN));
        chk("model_done",    int'(bus.done),    int'(m_state == M_DONE));
        chk("model_expire",  int'(bus.expire),  m_expire);
    end

    task automatic pulse(input logic l, input logic s, input logic p, input logic [3:0] pr);
        @(negedge clk);
        bus.load = l; bus.start = s; bus.pause = p; bus.preset = pr;
        @(posedge clk);
        #1;
        bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    endtask

    task automatic wait_change(input string nm, output int cyc);
        logic [3:0] prev;
        prev = bus.cnt;
        cyc  = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.cnt != prev) break;
            if (cyc >= 100) begin
                n_chk++;
                n_err++;
                $display("FAIL %s: cnt did not change within %0d cycles", nm, cyc);
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.preset = 4'd0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt",     int'(bus.cnt),     0);
        chk("rst_sec",     int'(bus.sec),     int'(10'b0000000001));
        chk("rst_running", int'(bus.running), 0);
        chk("rst_expire",  int'(bus.expire),  0);
        @(posedge clk); #2 rst = 1'b1;

        pulse(1'b1, 1'b0, 1'b0, 4'd3);
        chk("load3_cnt",  int'(bus.cnt),  3);
        chk("load3_sec",  int'(bus.sec),  int'(10'b0000001000));
        chk("load3_done", int'(bus.done), 0);

        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        chk("start_running", int'(bus.running), 1);
        wait_change("cd1", cyc); chk("cd_first_dec_cycles", cyc, 12); chk("cd_cnt2", int'(bus.cnt), 2);
        wait_change("cd2", cyc); chk("cd_second_dec_cycles", cyc, 12);
        wait_change("cd3", cyc); chk("cd_third_dec_cycles", cyc, 12);
        chk("cd_done",   int'(bus.done),   1);
        chk("cd_expire", int'(bus.expire), 1);
        @(posedge clk); #1;
        chk("cd_expire_once", int'(bus.expire), 0);
        chk("cd_done_hold",   int'(bus.done),   1);
        chk("cd_sec0",        int'(bus.sec),    int'(10'b0000000001));

        pulse(1'b1, 1'b0, 1'b0, 4'd5);
        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        repeat (4) @(posedge clk);
        pulse(1'b0, 1'b0, 1'b1, 4'd0);
        chk("pause_running", int'(bus.running), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("pause_cnt_held", int'(bus.cnt), 5);
        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        wait_change("resume", cyc); chk("resume_dec_cycles", cyc, 7); chk("resume_cnt", int'(bus.cnt), 4);

        pulse(1'b0, 1'b0, 1'b1, 4'd0);
        pulse(1'b1, 1'b0, 1'b0, 4'd12);
        chk("clamp_cnt", int'(bus.cnt), 9);
        chk("clamp_sec", int'(bus.sec), int'(10'b1000000000));

        pulse(1'b1, 1'b0, 1'b0, 4'd0);
        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        chk("zero_done",   int'(bus.done),   1);
        chk("zero_expire", int'(bus.expire), 1);
        chk("zero_cnt",    int'(bus.cnt),    0);

        pulse(1'b1, 1'b0, 1'b0, 4'd2);
        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        wait_change("p2a", cyc); wait_change("p2b", cyc);
        chk("p2_done", int'(bus.done), 1);
        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        chk("restart_cnt",     int'(bus.cnt),     2);
        chk("restart_running", int'(bus.running), 1);
        wait_change("p2c", cyc); wait_change("p2d", cyc);
        chk("restart_done", int'(bus.done), 1);
        chk("restart_cnt0", int'(bus.cnt),  0);

        pulse(1'b1, 1'b0, 1'b0, 4'd4);
        pulse(1'b1, 1'b1, 1'b0, 4'd6);
        chk("ldst_cnt",     int'(bus.cnt),     6);
        chk("ldst_running", int'(bus.running), 0);
        chk("ldst_done",    int'(bus.done),    0);

        pulse(1'b1, 1'b0, 1'b0, 4'd1);
        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        repeat (11) @(posedge clk);
        pulse(1'b0, 1'b0, 1'b1, 4'd0);
        chk("tickpause_done",   int'(bus.done),    1);
        chk("tickpause_expire", int'(bus.expire),  1);
        chk("tickpause_run",    int'(bus.running), 0);

        pulse(1'b1, 1'b0, 1'b0, 4'd7);
        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        repeat (36) @(posedge clk);
        #3;
        chk("arst_pre_cnt", int'(bus.cnt), 4);
        rst = 1'b0;
        #1;
        chk("arst_cnt",     int'(bus.cnt),     0);
        chk("arst_sec",     int'(bus.sec),     int'(10'b0000000001));
        chk("arst_running", int'(bus.running), 0);
        chk("arst_done",    int'(bus.done),    0);
        @(posedge clk); #2 rst = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        chk("arst_idle_start_done", int'(bus.done), 1);
        pulse(1'b0, 1'b1, 1'b0, 4'd0);
        chk("arst_preset_lost_cnt",  int'(bus.cnt),    0);
        chk("arst_preset_lost_exp",  int'(bus.expire), 1);

        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #2;
            bus.load   = ($urandom_range(15) == 0);
            bus.start  = ($urandom_range(5) == 0);
            bus.pause  = ($urandom_range(9) == 0);
            bus.preset = 4'($urandom_range(15));
            rst        = ($urandom_range(400) != 0);
        end
        @(posedge clk); #2;
        rst = 1'b1; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
